// File: rtl/ahb_flash_writer_seq.sv
// AHB-Lite slave that sequences whole-byte x1/x4 SPI mode-0 writes to a QSPI flash.
// It passes the flash-reader pins through until the WE key unlocks the engine.
module ahb_flash_writer_seq #(
  parameter int unsigned DIV_W  = 8,
  parameter logic [31:0] ID_VAL = 32'hABCD0002
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        fr_sck,
  input  logic        fr_ce_n,
  input  logic [3:0]  fr_dout,
  input  logic        fr_douten,
  output logic [3:0]  fr_din,
  output logic        fm_sck,
  output logic        fm_ce_n,
  output logic [3:0]  fm_dout,
  output logic [3:0]  fm_douten,
  input  logic [3:0]  fm_din
);

  localparam logic [7:0] A_WE     = 8'h00;
  localparam logic [7:0] A_CTRL   = 8'h04;
  localparam logic [7:0] A_TX     = 8'h08;
  localparam logic [7:0] A_RX     = 8'h0C;
  localparam logic [7:0] A_STATUS = 8'h10;
  localparam logic [7:0] A_ID     = 8'h14;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       addr_q;
  logic             write_q, vld_q;
  logic             we_q, we_d;
  logic             ss_q, ss_d;
  logic             quad_q, quad_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       unit_cnt_q, unit_cnt_d;
  logic [7:0]       sh_out_q, sh_out_d;
  logic [7:0]       sh_in_q, sh_in_d;
  logic [7:0]       rx_q, rx_d;
  logic             sck_q, sck_d;
  logic             ovr_q, ovr_d;

  logic             busy;
  logic             wr_vld;
  logic             tx_start;
  logic             phase_end;
  logic [3:0]       eng_dout;
  logic [31:0]      ctrl_rd;

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR[31:8]};

  assign busy      = (state_q != S_IDLE);
  assign wr_vld    = vld_q & write_q;
  assign tx_start  = wr_vld && (addr_q == A_TX) && we_q && !busy;
  assign phase_end = (div_cnt_q == div_q);
  assign eng_dout  = quad_q ? sh_out_q[7:4] : {3'b000, sh_out_q[7]};

  // Register file: WE key, CTRL (mode fields frozen while busy), sticky OVR.
  always_comb begin
    we_d   = we_q;
    ss_d   = ss_q;
    quad_d = quad_q;
    div_d  = div_q;
    ovr_d  = ovr_q;
    if (wr_vld) begin
      case (addr_q)
        A_WE: if (HWDATA[31:8] == 24'hA5A855) we_d = HWDATA[0];
        A_CTRL: begin
          ss_d = HWDATA[0];
          if (!busy) begin
            quad_d = HWDATA[1];
            div_d  = HWDATA[8 +: DIV_W];
          end
        end
        A_TX: if (we_q && busy) ovr_d = 1'b1;
        A_STATUS: if (HWDATA[1]) ovr_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Engine: each unit spends DIV+1 cycles with SCK low, then DIV+1 with SCK high.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    unit_cnt_d = unit_cnt_q;
    sh_out_d   = sh_out_q;
    sh_in_d    = sh_in_q;
    sck_d      = sck_q;
    rx_d       = rx_q;
    case (state_q)
      S_IDLE: begin
        sck_d = 1'b0;
        if (tx_start) begin
          sh_out_d   = HWDATA[7:0];
          unit_cnt_d = quad_q ? 4'd2 : 4'd8;
          div_cnt_d  = '0;
          state_d    = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          div_cnt_d = '0;
          sck_d     = 1'b1;
          sh_in_d   = quad_q ? {sh_in_q[3:0], fm_din} : {sh_in_q[6:0], fm_din[1]};
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          div_cnt_d  = '0;
          sck_d      = 1'b0;
          unit_cnt_d = unit_cnt_q - 4'd1;
          if (unit_cnt_q != 4'd1) begin
            sh_out_d = quad_q ? {sh_out_q[3:0], 4'b0000} : {sh_out_q[6:0], 1'b0};
            state_d  = S_LOW;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        rx_d    = sh_in_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Losing WE drops the transfer on the spot and leaves RX alone.
    if (!we_d) begin
      state_d   = S_IDLE;
      sck_d     = 1'b0;
      div_cnt_d = '0;
      rx_d      = rx_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      vld_q      <= 1'b0;
      we_q       <= 1'b0;
      ss_q       <= 1'b1;
      quad_q     <= 1'b0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      unit_cnt_q <= '0;
      sh_out_q   <= '0;
      sh_in_q    <= '0;
      rx_q       <= '0;
      sck_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      vld_q <= HSEL & HREADY & HTRANS[1];
      if (HSEL & HREADY & HTRANS[1]) begin
        addr_q  <= HADDR[7:0];
        write_q <= HWRITE;
      end
      state_q    <= state_d;
      we_q       <= we_d;
      ss_q       <= ss_d;
      quad_q     <= quad_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      unit_cnt_q <= unit_cnt_d;
      sh_out_q   <= sh_out_d;
      sh_in_q    <= sh_in_d;
      rx_q       <= rx_d;
      sck_q      <= sck_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[0]          = ss_q;
    ctrl_rd[1]          = quad_q;
    ctrl_rd[8 +: DIV_W] = div_q;
  end

  always_comb begin
    HRDATA = '0;
    case (addr_q)
      A_WE:     HRDATA = {31'b0, we_q};
      A_CTRL:   HRDATA = ctrl_rd;
      A_RX:     HRDATA = {24'b0, rx_q};
      A_STATUS: HRDATA = {30'b0, ovr_q, busy};
      A_ID:     HRDATA = ID_VAL;
      default:  HRDATA = '0;
    endcase
  end

  assign HREADYOUT = 1'b1;
  assign fr_din    = fm_din;
  assign fm_sck    = we_q ? sck_q : fr_sck;
  assign fm_ce_n   = we_q ? ss_q : fr_ce_n;
  assign fm_dout   = we_q ? eng_dout : fr_dout;
  assign fm_douten = we_q ? (quad_q ? 4'b1111 : 4'b0001) : {4{fr_douten}};

endmodule

// File: tb/tb_ahb_flash_writer_seq.sv
// Bench for ahb_flash_writer_seq: register table, directed x1/x4/OVR/abort/reset
// sequences and randomized transfers checked against a byte-level flash model.
module tb_ahb_flash_writer_seq;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL, HWRITE, HREADY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR, HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        fr_sck, fr_ce_n, fr_douten;
  logic [3:0]  fr_dout, fr_din;
  logic        fm_sck, fm_ce_n;
  logic [3:0]  fm_dout, fm_douten, fm_din;

  always #5 HCLK = ~HCLK;

  ahb_flash_writer_seq #(.DIV_W(8), .ID_VAL(32'hABCD0002)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HREADY(HREADY), .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .fr_sck(fr_sck), .fr_ce_n(fr_ce_n), .fr_dout(fr_dout), .fr_douten(fr_douten),
    .fr_din(fr_din), .fm_sck(fm_sck), .fm_ce_n(fm_ce_n), .fm_dout(fm_dout),
    .fm_douten(fm_douten), .fm_din(fm_din)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flash model: presents the reply byte one unit per SCK rise.
  logic [7:0] reply = 8'h00;
  logic       reply_quad = 1'b0;
  logic       idx_clr = 1'b0;
  int         unit_idx = 0;

  always @(posedge fm_sck or posedge idx_clr) begin
    if (idx_clr) unit_idx = 0;
    else         unit_idx = unit_idx + 1;
  end

  always_comb begin
    fm_din = 4'b0000;
    if (reply_quad) fm_din = (unit_idx == 0) ? reply[7:4] : reply[3:0];
    else if (unit_idx < 8) fm_din[1] = reply[3'(7 - unit_idx)];
  end

  // Pin monitor: data seen at each SCK rise and the width of each high phase.
  logic       prev_sck = 1'b0;
  int         hi_run = 0;
  logic [3:0] dq[$];
  int         widths[$];

  always @(negedge HCLK) begin
    if (fm_sck && !prev_sck) dq.push_back(fm_dout);
    if (fm_sck) hi_run++;
    else if (prev_sck) begin
      widths.push_back(hi_run);
      hi_run = 0;
    end
    prev_sck = fm_sck;
  end

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  // Write, with a STATUS read pipelined into the data phase so HRDATA tracks STATUS afterwards.
  task automatic wr_pipe_status(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HWDATA = d; HWRITE = 1'b0; HADDR = 32'h10;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] v;
    int guard;
    guard = 0;
    ahb_read(8'h10, v);
    while (v[0] === 1'b1 && guard < 500) begin
      ahb_read(8'h10, v);
      guard++;
    end
    chk({tag, " idle_timeout"}, 32'(guard >= 500), 32'd0);
  endtask

  function automatic logic [3:0] exp_unit(input logic [7:0] b, input logic quad, input int i);
    if (quad) return (i == 0) ? b[7:4] : b[3:0];
    return {3'b000, b[3'(7 - i)]};
  endfunction

  function automatic logic [31:0] ctrl_word(input int div, input logic quad, input logic ss);
    return (32'(div) << 8) | (32'(quad) << 1) | 32'(ss);
  endfunction

  task automatic arm_flash(input logic [7:0] rep, input logic quad);
    reply = rep; reply_quad = quad;
    idx_clr = 1'b1; #1 idx_clr = 1'b0;
    dq.delete(); widths.delete();
  endtask

  logic [7:0] last_rx = 8'h00;

  task automatic run_tx(input string tag, input logic [7:0] data, input logic quad,
                        input int div, input logic [7:0] rep);
    int n, busy_cyc, guard;
    logic [31:0] v;
    n = quad ? 2 : 8;
    ahb_write(8'h04, ctrl_word(div, quad, 1'b0));
    chk({tag, " douten"}, 32'(fm_douten), quad ? 32'hF : 32'h1);
    chk({tag, " ce_n"}, 32'(fm_ce_n), 32'd0);
    arm_flash(rep, quad);
    wr_pipe_status(8'h08, {24'h0, data});
    chk({tag, " busy_first"}, 32'(HRDATA[0]), 32'd1);
    chk({tag, " first_unit"}, 32'(fm_dout), 32'(exp_unit(data, quad, 0)));
    busy_cyc = 0; guard = 0;
    while (HRDATA[0] === 1'b1 && guard < 4000) begin
      busy_cyc++; guard++;
      @(posedge HCLK); #1;
    end
    chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(2 * n * (div + 1) + 1));
    chk({tag, " sck_pulses"}, 32'(widths.size()), 32'(n));
    chk({tag, " dout_units"}, 32'(dq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, " dout"}, 32'(dq[i]), 32'(exp_unit(data, quad, i)));
      chk({tag, " sck_high"}, 32'(widths[i]), 32'(div + 1));
    end
    ahb_read(8'h0C, v);
    chk({tag, " rx"}, v, {24'h0, rep});
    last_rx = rep;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [31:0] v;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
    HSIZE = 3'b010; HADDR = '0; HWDATA = '0;
    fr_sck = 1'b0; fr_ce_n = 1'b1; fr_dout = 4'h0; fr_douten = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;

    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hrdata", HRDATA, 32'd0);
    for (int i = 0; i < 4; i++) begin
      fr_sck = i[0]; fr_douten = i[1]; fr_dout = 4'(i * 5);
      #1;
      chk("pass_sck", 32'(fm_sck), 32'(i[0]));
      chk("pass_douten", 32'(fm_douten), {28'h0, {4{i[1]}}});
      chk("pass_dout", 32'(fm_dout), 32'(i * 5));
    end
    fr_sck = 1'b0; fr_douten = 1'b0;

    vt[0]  = '{1'b0, 8'h14, 32'h0, 32'hABCD0002};
    vt[1]  = '{1'b0, 8'h00, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 8'h04, 32'h0, 32'h1};
    vt[3]  = '{1'b0, 8'h0C, 32'h0, 32'h0};
    vt[4]  = '{1'b0, 8'h10, 32'h0, 32'h0};
    vt[5]  = '{1'b0, 8'h20, 32'h0, 32'h0};
    vt[6]  = '{1'b1, 8'h00, 32'h12345601, 32'h0};
    vt[7]  = '{1'b0, 8'h00, 32'h0, 32'h0};
    vt[8]  = '{1'b1, 8'h08, 32'h000000FF, 32'h0};
    vt[9]  = '{1'b0, 8'h10, 32'h0, 32'h0};
    vt[10] = '{1'b1, 8'h00, 32'hA5A85501, 32'h0};
    vt[11] = '{1'b0, 8'h00, 32'h0, 32'h1};
    vt[12] = '{1'b1, 8'h04, 32'h00000302, 32'h0};
    vt[13] = '{1'b0, 8'h04, 32'h0, 32'h302};
    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) ahb_write(vt[i].addr, vt[i].wdata);
      else begin
        ahb_read(vt[i].addr, v);
        chk($sformatf("reg_vec%0d", i), v, vt[i].exp);
      end
    end
    ahb_write(8'h04, 32'h1);
    chk("unlocked_ce_n", 32'(fm_ce_n), 32'd1);
    chk("unlocked_douten", 32'(fm_douten), 32'h1);

    run_tx("x1", 8'hA5, 1'b0, 0, 8'h3C);
    run_tx("x4", 8'h9E, 1'b1, 3, 8'h71);

    // Overrun: the byte in flight survives, OVR sticks, mode fields are frozen.
    ahb_write(8'h04, ctrl_word(2, 1'b0, 1'b0));
    arm_flash(8'h5A, 1'b0);
    ahb_write(8'h08, 32'hC3);
    ahb_write(8'h08, 32'hFF);
    ahb_write(8'h04, 32'h303);
    wait_idle("ovr");
    ahb_read(8'h10, v);
    chk("ovr_set", v, 32'h2);
    ahb_read(8'h04, v);
    chk("ctrl_frozen", v, 32'h201);
    chk("ovr_units", 32'(dq.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("ovr_dout", 32'(dq[i]), 32'(exp_unit(8'hC3, 1'b0, i)));
    ahb_read(8'h0C, v);
    chk("ovr_rx", v, 32'h5A);
    ahb_write(8'h10, 32'h2);
    ahb_read(8'h10, v);
    chk("ovr_clear", v, 32'h0);

    for (int k = 0; k < 6; k++) begin
      run_tx($sformatf("rnd%0d", k), 8'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 4)), 8'($urandom));
    end

    // Abort by clearing WE mid-transfer.
    ahb_write(8'h04, ctrl_word(3, 1'b0, 1'b0));
    arm_flash(8'hE7, 1'b0);
    ahb_write(8'h08, 32'h81);
    repeat (9) @(posedge HCLK);
    #1;
    fr_sck = 1'b1; fr_ce_n = 1'b1; fr_dout = 4'hA; fr_douten = 1'b0;
    wr_pipe_status(8'h00, 32'hA5A85500);
    chk("abort_busy", HRDATA, 32'h0);
    chk("abort_sck", 32'(fm_sck), 32'd1);
    chk("abort_ce_n", 32'(fm_ce_n), 32'd1);
    chk("abort_dout", 32'(fm_dout), 32'hA);
    chk("abort_douten", 32'(fm_douten), 32'h0);
    chk("abort_frdin", 32'(fr_din), 32'(fm_din));
    ahb_read(8'h0C, v);
    chk("abort_rx", v, {24'h0, last_rx});

    // Synchronous reset mid-transfer.
    fr_sck = 1'b0; fr_ce_n = 1'b0; fr_dout = 4'h6; fr_douten = 1'b1;
    ahb_write(8'h00, 32'hA5A85501);
    ahb_write(8'h04, ctrl_word(2, 1'b1, 1'b0));
    arm_flash(8'h42, 1'b1);
    ahb_write(8'h08, 32'h3C);
    repeat (4) @(posedge HCLK);
    #1 HRESET = 1'b1;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    chk("rst_mid_hrdata", HRDATA, 32'h0);
    chk("rst_mid_sck", 32'(fm_sck), 32'd0);
    chk("rst_mid_ce_n", 32'(fm_ce_n), 32'd0);
    chk("rst_mid_dout", 32'(fm_dout), 32'h6);
    chk("rst_mid_douten", 32'(fm_douten), 32'hF);
    ahb_read(8'h04, v);
    chk("rst_mid_ctrl", v, 32'h1);
    ahb_read(8'h10, v);
    chk("rst_mid_status", v, 32'h0);
    ahb_read(8'h0C, v);
    chk("rst_mid_rx", v, 32'h0);
    ahb_read(8'h00, v);
    chk("rst_mid_we", v, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
